// File: rtl/layered_rgb_mux_if.sv
// rtl/layered_rgb_mux_if.sv - pixel-in / composited-pixel-out bundle for layered_rgb_mux
interface layered_rgb_mux_if #(
  parameter int NUM_LAYERS = 4,
  parameter int RGB_W      = 8
);
  localparam int IDX_W = $clog2(NUM_LAYERS + 1);

  logic                        pixelValid;
  logic                        startOfFrame;
  logic [NUM_LAYERS-1:0]       drawingRequest;
  logic [NUM_LAYERS*RGB_W-1:0] layerRGB;
  logic [RGB_W-1:0]            backGroundRGB;
  logic [NUM_LAYERS-1:0]       layerEnable;

  logic [RGB_W-1:0]            RGBOut;
  logic                        RGBValid;
  logic [IDX_W-1:0]            winningLayer;
  logic                        collisionPulse;
  logic [NUM_LAYERS-1:0]       collisionFlags;

  modport master (
    output pixelValid, startOfFrame, drawingRequest, layerRGB, backGroundRGB, layerEnable,
    input  RGBOut, RGBValid, winningLayer, collisionPulse, collisionFlags
  );

  modport slave (
    input  pixelValid, startOfFrame, drawingRequest, layerRGB, backGroundRGB, layerEnable,
    output RGBOut, RGBValid, winningLayer, collisionPulse, collisionFlags
  );
endinterface

// File: rtl/layered_rgb_mux.sv
// rtl/layered_rgb_mux.sv - 2-stage priority compositor of NUM_LAYERS layers over a background
// Optional collision reporting built only when LAYER_COLLISION_EN is defined.
module layered_rgb_mux #(
  parameter int               NUM_LAYERS      = 4,
  parameter int               RGB_W           = 8,
  parameter logic [RGB_W-1:0] TRANSPARENT_RGB = {RGB_W{1'b1}}
) (
  input logic               clk,
  input logic               reset,
  layered_rgb_mux_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_LAYERS + 1);

  logic [NUM_LAYERS-1:0]       eff_in;
  logic [NUM_LAYERS-1:0]       s1_eff;
  logic [NUM_LAYERS*RGB_W-1:0] s1_rgb;
  logic [RGB_W-1:0]            s1_bg;
  logic                        s1_valid;
  logic                        s1_sof;

  logic [RGB_W-1:0]            sel_rgb;
  logic [IDX_W-1:0]            sel_idx;

  logic [RGB_W-1:0]            rgb_q;
  logic                        valid_q;
  logic [IDX_W-1:0]            win_q;

  // Mask and colour key are resolved before registering so a mask change cannot touch pixels in flight.
  always_comb begin
    eff_in = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      eff_in[i] = bus.drawingRequest[i] & bus.layerEnable[i] &
                  (bus.layerRGB[i*RGB_W +: RGB_W] != TRANSPARENT_RGB);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_eff   <= '0;
      s1_rgb   <= '0;
      s1_bg    <= '0;
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
    end else begin
      s1_eff   <= eff_in;
      s1_rgb   <= bus.layerRGB;
      s1_bg    <= bus.backGroundRGB;
      s1_valid <= bus.pixelValid;
      s1_sof   <= bus.startOfFrame;
    end
  end

  // Scan from the lowest priority upward so the lowest drawing index wins.
  always_comb begin
    sel_rgb = s1_bg;
    sel_idx = IDX_W'(NUM_LAYERS);
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (s1_eff[i]) begin
        sel_rgb = s1_rgb[i*RGB_W +: RGB_W];
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q   <= '0;
      valid_q <= 1'b0;
      win_q   <= IDX_W'(NUM_LAYERS);
    end else begin
      valid_q <= s1_valid;
      if (s1_valid) begin
        rgb_q <= sel_rgb;
        win_q <= sel_idx;
      end
    end
  end

  assign bus.RGBOut       = rgb_q;
  assign bus.RGBValid     = valid_q;
  assign bus.winningLayer = win_q;

`ifdef LAYER_COLLISION_EN
  logic                  multi_hit;
  logic [NUM_LAYERS-1:0] hit_mask;
  logic [NUM_LAYERS-1:0] acc;
  logic [NUM_LAYERS-1:0] flags_q;
  logic                  pulse_q;

  // Clearing the lowest set bit leaves something only when two or more layers drew.
  assign multi_hit = |(s1_eff & (s1_eff - NUM_LAYERS'(1)));
  assign hit_mask  = (s1_valid && multi_hit) ? s1_eff : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      flags_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      if (s1_valid) begin
        pulse_q <= multi_hit;
      end
      if (s1_sof) begin
        flags_q <= acc;
        acc     <= hit_mask;
      end else begin
        acc     <= acc | hit_mask;
      end
    end
  end

  assign bus.collisionPulse = pulse_q;
  assign bus.collisionFlags = flags_q;
`else
  logic sof_unused;
  assign sof_unused         = s1_sof;
  assign bus.collisionPulse = 1'b0;
  assign bus.collisionFlags = '0;
`endif

endmodule

// File: tb/tb_layered_rgb_mux.sv
// tb/tb_layered_rgb_mux.sv - randomized + directed check of layered_rgb_mux against a pixel-level model
module tb_layered_rgb_mux;
  localparam int NL = 4;
  localparam int W  = 8;
`ifdef LAYER_COLLISION_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  layered_rgb_mux_if #(.NUM_LAYERS(NL), .RGB_W(W)) bus ();

  layered_rgb_mux #(.NUM_LAYERS(NL), .RGB_W(W), .TRANSPARENT_RGB(8'hFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          valid;
    bit          sof;
    bit [NL-1:0] eff;
    bit [7:0]    rgb;
    int          win;
  } rec_t;

  rec_t s1;
  int   m_rgb, m_win, m_valid, m_pulse, m_flags, m_acc;
  bit   ready = 1'b0;
  bit   coll;

  function automatic int popc(input bit [NL-1:0] v);
    int c = 0;
    for (int i = 0; i < NL; i++) c += int'(v[i]);
    return c;
  endfunction

  // What the current input pixel means: who draws, and who wins.
  function automatic rec_t make_rec();
    rec_t r;
    bit found = 1'b0;
    r.valid = bus.pixelValid;
    r.sof   = bus.startOfFrame;
    r.eff   = '0;
    for (int i = 0; i < NL; i++)
      if (bus.drawingRequest[i] && bus.layerEnable[i] && bus.layerRGB[i*W +: W] != 8'hFF)
        r.eff[i] = 1'b1;
    r.win = NL;
    r.rgb = bus.backGroundRGB;
    for (int i = 0; i < NL; i++)
      if (!found && r.eff[i]) begin
        found = 1'b1;
        r.win = i;
        r.rgb = bus.layerRGB[i*W +: W];
      end
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_rgb = 0; m_win = NL; m_valid = 0; m_pulse = 0; m_flags = 0; m_acc = 0;
      s1 = '{default: 0};
      ready = 1'b1;
    end else begin
      coll = popc(s1.eff) >= 2;
      if (s1.sof) begin
        m_flags = m_acc;
        m_acc   = (s1.valid && coll) ? int'(s1.eff) : 0;
      end else if (s1.valid && coll) begin
        m_acc = m_acc | int'(s1.eff);
      end
      if (s1.valid) begin
        m_rgb   = s1.rgb;
        m_win   = s1.win;
        m_pulse = coll;
      end
      m_valid = s1.valid;
      s1 = make_rec();
    end
  end

  always @(negedge clk) begin
    if (ready) begin
      check("rgb",   bus.RGBOut,         m_rgb);
      check("valid", bus.RGBValid,       m_valid);
      check("win",   bus.winningLayer,   m_win);
      check("pulse", bus.collisionPulse, COLL ? m_pulse : 0);
      check("flags", bus.collisionFlags, COLL ? m_flags : 0);
    end
  end

  task automatic drive(input bit v, input bit sof, input bit [3:0] req, input bit [3:0] en,
                       input bit [31:0] cols, input bit [7:0] bg);
    bus.pixelValid     = v;
    bus.startOfFrame   = sof;
    bus.drawingRequest = req;
    bus.layerEnable    = en;
    bus.layerRGB       = cols;
    bus.backGroundRGB  = bg;
  endtask

  // Present one pixel, follow with an invalid bubble, then look at the result two edges later.
  task automatic pixel(input bit v, input bit sof, input bit [3:0] req, input bit [3:0] en,
                       input bit [31:0] cols, input bit [7:0] bg);
    @(negedge clk);
    drive(v, sof, req, en, cols, bg);
    @(negedge clk);
    drive(0, 0, 4'h0, 4'hF, 32'h0, 8'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit [31:0] cols;
    drive(0, 0, 4'h0, 4'hF, 32'h0, 8'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_valid", bus.RGBValid, 0);
    check("rst_win",   bus.winningLayer, 4);
    check("rst_flags", bus.collisionFlags, 0);
    @(negedge clk);
    reset = 1'b0;

    pixel(1, 0, 4'b1010, 4'hF, {8'hE0, 8'h00, 8'h1C, 8'h00}, 8'h00);
    check("prio_rgb", bus.RGBOut, 8'h1C);
    check("prio_win", bus.winningLayer, 1);
    check("prio_valid", bus.RGBValid, 1);

    pixel(1, 0, 4'b0101, 4'b1011, {8'h00, 8'h03, 8'h00, 8'hFF}, 8'h49);
    check("key_rgb", bus.RGBOut, 8'h49);
    check("key_win", bus.winningLayer, 4);
    check("key_pulse", bus.collisionPulse, 0);

    pixel(1, 1, 4'h0, 4'hF, 32'h0, 8'h11);
    check("sof1_flags", bus.collisionFlags, COLL ? 4'b1010 : 4'b0000);

    pixel(1, 0, 4'b0101, 4'hF, {8'h00, 8'h20, 8'h00, 8'h10}, 8'h00);
    check("coll_rgb", bus.RGBOut, 8'h10);
    check("coll_win", bus.winningLayer, 0);
    check("coll_pulse", bus.collisionPulse, COLL ? 1 : 0);

    pixel(1, 1, 4'h0, 4'hF, 32'h0, 8'h22);
    check("sof2_flags", bus.collisionFlags, COLL ? 4'b0101 : 4'b0000);
    check("sof2_pulse", bus.collisionPulse, 0);

    pixel(1, 0, 4'b0001, 4'hF, 32'h0000_0033, 8'h00);
    pixel(1, 1, 4'h0, 4'hF, 32'h0, 8'h5A);
    check("clean_flags", bus.collisionFlags, 0);

    pixel(0, 0, 4'b0101, 4'hF, {8'h00, 8'h20, 8'h00, 8'h10}, 8'h00);
    check("inv_rgb", bus.RGBOut, 8'h5A);
    check("inv_valid", bus.RGBValid, 0);
    pixel(1, 1, 4'h0, 4'hF, 32'h0, 8'h00);
    check("inv_flags", bus.collisionFlags, 0);

    @(negedge clk);
    drive(1, 0, 4'b0101, 4'hF, {8'h00, 8'h20, 8'h00, 8'h10}, 8'h00);
    @(negedge clk);
    drive(1, 0, 4'b0011, 4'hF, {8'h00, 8'h00, 8'h21, 8'h12}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_rgb", bus.RGBOut, 0);
    check("mid_rst_valid", bus.RGBValid, 0);
    check("mid_rst_win", bus.winningLayer, 4);
    check("mid_rst_pulse", bus.collisionPulse, 0);
    @(negedge clk);
    reset = 1'b0;
    pixel(1, 1, 4'h0, 4'hF, 32'h0, 8'h00);
    check("post_rst_flags", bus.collisionFlags, 0);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int i = 0; i < NL; i++)
        cols[i*W +: W] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      drive($urandom_range(0, 4) != 0, $urandom_range(0, 39) == 0, 4'($urandom),
            ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF, cols, 8'($urandom));
      reset = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 4'h0, 4'hF, 32'h0, 8'h0);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/layered_rgb_mux.md
# layered_rgb_mux

Parametrised, pipelined priority compositor that merges NUM_LAYERS sprite/object layers over a background into the 8-bit VGA pixel stream. It sits between the object drawers and the VGA output stage. It replaces fixed-count priority muxing with per-layer enable, colour-key transparency, a 2-stage pipeline with valid tagging, and per-frame collision reporting for game logic.

## Interface
- NUM_LAYERS, 4: number of object layers; legal range 2..16; layer 0 has highest priority.
- RGB_W, 8: pixel colour width.
- TRANSPARENT_RGB, 8'hFF: colour key; a layer pixel equal to it never draws.
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- pixelValid  in  1  current inputs carry a visible pixel.
- startOfFrame  in  1  one-cycle pulse coincident with the first pixel of a frame.
- drawingRequest  in  NUM_LAYERS  per-layer draw request; bit i belongs to layer i.
- layerRGB  in  NUM_LAYERS*RGB_W  packed colours; layer i at [i*RGB_W +: RGB_W].
- backGroundRGB  in  RGB_W  lowest-priority colour.
- layerEnable  in  NUM_LAYERS  per-layer mask; 0 removes the layer from output and collisions.
- RGBOut  out  RGB_W  composited pixel.
- RGBValid  out  1  RGBOut carries a valid pixel.
- winningLayer  out  $clog2(NUM_LAYERS+1)  index of the selected layer; NUM_LAYERS means background.
- collisionPulse  out  1  two or more layers effectively drew this pixel (collision build only).
- collisionFlags  out  NUM_LAYERS  layers involved in any collision during the previous frame (collision build only).

## Operation
- Effective request: eff[i] = drawingRequest[i] & layerEnable[i] & (layerRGB[i] != TRANSPARENT_RGB).
- Stage 1 registers eff, all layer colours, backGroundRGB, pixelValid and startOfFrame as tags.
- Stage 2 selects the lowest index i with eff[i]=1, giving RGBOut = layerRGB[i] and winningLayer = i.
  - If no eff bit is set: RGBOut = backGroundRGB, winningLayer = NUM_LAYERS.
- Invalid pixels: RGBOut, winningLayer and collisionPulse hold their previous values. RGBValid = 0. The collision accumulator is unchanged.
- Collision accumulator acc[NUM_LAYERS], updated only on valid stage-2 pixels.
  - When popcount(eff) >= 2: acc |= eff and collisionPulse = 1. Otherwise collisionPulse = 0.
- Frame boundary: when the startOfFrame tag reaches stage 2, collisionFlags <= acc.
  - acc <= the contribution of that same pixel only, because that pixel belongs to the new frame.
  - This happens whether or not that pixel is valid; an invalid pixel contributes 0.
- Two startOfFrame pulses one cycle apart: the second transfers only the first pixel's contribution, with no loss or merging.
- layerEnable, TRANSPARENT_RGB and priority are evaluated in the input cycle. A mask change takes effect on the next pixel without glitching pixels already in flight.
- No handshake or backpressure: the pipeline advances every cycle.

## Timing
- Latency: inputs at cycle n appear on RGBOut, RGBValid, winningLayer and collisionPulse at cycle n+2.
- collisionFlags updates at n+2 for a startOfFrame sampled at n. It is stable for the whole following frame.
- Reset, sampled on a clk edge with reset=1:
  - RGBOut=0, RGBValid=0, winningLayer=NUM_LAYERS, collisionPulse=0, collisionFlags=0, acc=0.
  - Both pipeline stages' valid and startOfFrame tags are cleared.
- Reset mid-frame discards in-flight pixels and pending collisions. The first post-reset valid output appears 2 cycles after the first valid input.
- Throughput: one pixel per clock.

## Configuration
- LAYER_COLLISION_EN defined: accumulator, collisionPulse and collisionFlags are implemented as described.
- LAYER_COLLISION_EN undefined: no accumulator or popcount logic is built. collisionPulse and collisionFlags are tied to 0. Compositing and latency are unchanged.

## Test plan
- Priority, NUM_LAYERS=4: eff=4'b1010, layer1=8'h1C, layer3=8'hE0, valid. After 2 clocks, RGBOut=8'h1C, winningLayer=1, RGBValid=1.
- Transparency and mask: layer0 request with colour 8'hFF, layer2 request 8'h03 with layerEnable[2]=0, background 8'h49. Output is 8'h49 with winningLayer=4 and collisionPulse=0.
- Collision report: layers 0 and 2 both draw valid pixels mid-frame, then startOfFrame is pulsed. collisionPulse=1 on the overlap pixel; collisionFlags=4'b0101 two cycles after startOfFrame; flags return to 0 after a collision-free frame.
- Invalid pixel: pixelValid=0 with colliding requests. RGBOut holds, RGBValid=0, and acc is unchanged (verified at the next startOfFrame).
- Reset mid-frame: assert reset for 1 clock with colliding pixels in flight. All outputs are at reset values next cycle, and the next frame's collisionFlags=0.
- Macro off: repeat the collision-report scenario without LAYER_COLLISION_EN. collisionFlags and collisionPulse stay 0 and RGBOut matches the collision build exactly.
